// File: rtl/mux_pkg.sv
// Shared constants, the output-register state type and the round-robin search
// used by the 4:1 stream collector.
package mux_pkg;

  localparam int unsigned CH_N  = 4;
  localparam int unsigned SEL_W = 2;

  // The output register is either empty or holds one word.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Returns {found, idx}: the first requesting channel after ptr, wrapping.
  function automatic logic [SEL_W:0] rr_pick(input logic [CH_N-1:0]  req,
                                             input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = '0;
    found   = 1'b0;
    for (int unsigned k = 1; k <= CH_N; k++) begin
      idx = ptr + SEL_W'(k);
      if (req[idx] && !found) begin
        found   = 1'b1;
        rr_pick = {1'b1, idx};
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational round-robin arbiter: one-hot grant among four requests,
// searching upward from the channel after the last grant.
module rr_arbiter_4
  import mux_pkg::*;
(
  input  logic [CH_N-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [CH_N-1:0]  gnt
);

  logic [SEL_W:0] pick;

  always_comb begin
    pick = rr_pick(req, ptr);
    gnt  = '0;
    if (en && pick[SEL_W]) begin
      gnt[pick[SEL_W-1:0]] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_mux_4to1.sv
// Registered 4:1 stream collector: round-robin selects one of four valid/ready
// channels into a single output register tagged with its source index.
module rr_mux_4to1
  import mux_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CH_N-1:0]        in_valid,
  input  logic [CH_N*DATA_W-1:0] in_data,
  output logic [CH_N-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_sel,
  input  logic                   out_ready
);

  state_t             state;
  state_t             state_next;
  logic [SEL_W-1:0]   ptr;
  logic               load;
  logic               found;
  logic [CH_N-1:0]    gnt;
  logic [SEL_W-1:0]   gnt_idx;
  logic [DATA_W-1:0]  gnt_data;

  assign out_valid = (state == ST_FULL);
  assign load      = ~out_valid | out_ready;

  // Gating with rst_n keeps in_ready low for the whole time reset is held.
  rr_arbiter_4 u_arb (
    .req (in_valid),
    .ptr (ptr),
    .en  (load & rst_n),
    .gnt (gnt)
  );

  assign in_ready = gnt;
  assign found    = |gnt;

  // AND-OR select: non-granted channels never reach out_data, even if X.
  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int unsigned i = 0; i < CH_N; i++) begin
      if (gnt[i]) begin
        gnt_idx  = SEL_W'(i);
        gnt_data = gnt_data | in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_next = state;
    if (load) begin
      state_next = found ? ST_FULL : ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= '0;
      ptr      <= SEL_W'(CH_N - 1);
    end else if (load && found) begin
      out_data <= gnt_data;
      out_sel  <= gnt_idx;
      ptr      <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_rr_mux_4to1.sv
// Directed and randomized self-checking bench for rr_mux_4to1.
module tb_rr_mux_4to1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int n_assert = 0;
  int n_fail   = 0;

  rr_mux_4to1 #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [7:0] d);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, ".sel"},   {30'd0, out_sel},   {30'd0, s});
    chk({tag, ".data"},  {24'd0, out_data},  {24'd0, d});
  endtask

  initial begin
    int          mptr;
    logic        mvalid, mload;
    logic [1:0]  ms;
    logic [7:0]  md;
    logic [3:0]  eg;
    int          wait_cnt [4];
    int          s;

    // Reset with all channels requesting: nothing may be granted.
    rst_n     = 1'b0;
    in_valid  = 4'hF;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    out_ready = 1'b1;
    #12;
    chk_out("reset", 1'b0, 2'd0, 8'h00);
    chk("reset.in_ready", {28'd0, in_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_grant.in_ready", {28'd0, in_ready}, 32'h1);
    tick();
    chk_out("first_grant", 1'b1, 2'd0, 8'h11);

    // All valid, out_ready high: 1,2,3,0,... back to back.
    for (int j = 0; j < 8; j++) begin
      s = (j + 1) % 4;
      chk("rr.in_ready", {28'd0, in_ready}, 32'(1 << s));
      tick();
      chk_out("rr", 1'b1, 2'(s), 8'(8'h11 * (s + 1)));
    end

    // Single channel 2.
    in_valid = 4'b0100;
    in_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
    #1;
    chk("single.in_ready", {28'd0, in_ready}, 32'h4);
    tick();
    chk_out("single", 1'b1, 2'd2, 8'hA5);

    // Backpressure holding a channel-1 word.
    in_valid = 4'b0010;
    in_data  = {8'h44, 8'hA5, 8'h3C, 8'h11};
    #1;
    chk("bp_load.in_ready", {28'd0, in_ready}, 32'h2);
    tick();
    chk_out("bp_load", 1'b1, 2'd1, 8'h3C);
    out_ready = 1'b0;
    in_valid  = 4'b0110;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("bp_hold.in_ready", {28'd0, in_ready}, 32'h0);
      tick();
      chk_out("bp_hold", 1'b1, 2'd1, 8'h3C);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release.in_ready", {28'd0, in_ready}, 32'h4);
    tick();
    chk_out("bp_release", 1'b1, 2'd2, 8'hA5);

    // Wrap from ptr=3.
    in_valid = 4'b1000;
    in_data  = {8'h5A, 8'hA5, 8'h3C, 8'h0F};
    #1;
    chk("wrap_set.in_ready", {28'd0, in_ready}, 32'h8);
    tick();
    chk_out("wrap_set", 1'b1, 2'd3, 8'h5A);
    in_valid = 4'b1001;
    #1;
    chk("wrap0.in_ready", {28'd0, in_ready}, 32'h1);
    tick();
    chk_out("wrap0", 1'b1, 2'd0, 8'h0F);
    chk("wrap3.in_ready", {28'd0, in_ready}, 32'h8);
    tick();
    chk_out("wrap3", 1'b1, 2'd3, 8'h5A);

    // No request: register drains, data and sel hold.
    in_valid = 4'b0000;
    #1;
    chk("idle.in_ready", {28'd0, in_ready}, 32'h0);
    tick();
    chk_out("idle", 1'b0, 2'd3, 8'h5A);

    // Reset mid-operation with a held word.
    in_valid = 4'b0010;
    tick();
    chk_out("mid_load", 1'b1, 2'd1, 8'h3C);
    out_ready = 1'b0;
    in_valid  = 4'hF;
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("mid_reset", 1'b0, 2'd0, 8'h00);
    chk("mid_reset.in_ready", {28'd0, in_ready}, 32'h0);
    tick();
    chk("mid_reset_hold.in_ready", {28'd0, in_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_release.in_ready", {28'd0, in_ready}, 32'h1);
    tick();
    chk_out("mid_release", 1'b1, 2'd0, 8'h0F);

    // Random traffic against a reference model of the arbiter and register.
    mvalid = 1'b1;
    mptr   = 0;
    ms     = 2'd0;
    md     = 8'h0F;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) in_valid[i] = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      mload = !mvalid || out_ready;
      eg    = 4'b0000;
      if (mload) begin
        for (int k = 1; k <= 4; k++) begin
          if (eg == 4'b0000 && in_valid[(mptr + k) % 4]) eg[(mptr + k) % 4] = 1'b1;
        end
      end
      chk("rnd.in_ready", {28'd0, in_ready}, {28'd0, eg});
      chk("rnd.onehot", {31'd0, $onehot0(in_ready)}, 32'd1);
      chk("rnd.no_req_gnt", {28'd0, in_ready & ~in_valid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
        if (in_ready[i] || !in_valid[i]) wait_cnt[i] = 0;
        else if (mload) wait_cnt[i]++;
        chk("rnd.fairness", {31'd0, wait_cnt[i] <= 3}, 32'd1);
      end
      if (mload) mvalid = (eg != 4'b0000);
      for (int i = 0; i < 4; i++) begin
        if (eg[i]) begin
          mptr = i;
          ms   = 2'(i);
          md   = in_data[i*8 +: 8];
        end
      end
      tick();
      chk_out("rnd", mvalid, ms, md);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
